// File: rtl/alu_seq_ctrl.sv
// Sequential 32-bit ALU with a valid/ready request port and a valid/ready result port.
// Single-cycle ops go through EXEC; MUL runs a 32-step shift-add loop before DONE.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [31:0] a_reg, b_reg, acc_reg, result_reg;
    logic [5:0]  cnt_reg;
    logic        zero_reg;
    logic        ready_en_reg;
    logic        accept;
    logic [31:0] exec_value, acc_next;

    assign accept   = in_valid & in_ready;
    assign acc_next = acc_reg + (b_reg[0] ? a_reg : 32'h0);
    assign result   = result_reg;
    assign zero     = zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (op == OP_MUL) ? MUL : EXEC;
            EXEC: state_next = DONE;
            MUL:  if (cnt_reg == 6'd31) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is held off until the first edge after reset release
    always_comb begin
        in_ready  = (state_reg == IDLE) && ready_en_reg;
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    always_comb begin
        exec_value = 32'h0;
        case (op_reg)
            OP_ADD:  exec_value = a_reg + b_reg;
            OP_SUB:  exec_value = a_reg - b_reg;
            OP_AND:  exec_value = a_reg & b_reg;
            OP_OR:   exec_value = a_reg | b_reg;
            OP_SLT:  exec_value = {31'h0, $signed(a_reg) < $signed(b_reg)};
            default: exec_value = 32'h0;
        endcase
    end

    // MUL: a_reg is the shifting multiplicand, b_reg the multiplier consumed LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= 3'd0;
            a_reg        <= 32'h0;
            b_reg        <= 32'h0;
            acc_reg      <= 32'h0;
            cnt_reg      <= 6'd0;
            result_reg   <= 32'h0;
            zero_reg     <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept) begin
                op_reg  <= op;
                a_reg   <= a;
                b_reg   <= b;
                acc_reg <= 32'h0;
                cnt_reg <= 6'd0;
            end else if (state_reg == EXEC) begin
                result_reg <= exec_value;
                zero_reg   <= ~|exec_value;
            end else if (state_reg == MUL) begin
                acc_reg <= acc_next;
                a_reg   <= a_reg << 1;
                b_reg   <= b_reg >> 1;
                cnt_reg <= cnt_reg + 6'd1;
                if (cnt_reg == 6'd31) begin
                    result_reg <= acc_next;
                    zero_reg   <= ~|acc_next;
                end
            end
        end
    end
endmodule
